// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel frame loader.
// Holds the default frame geometry, the pixel width, the watchdog limit and the loader state encoding.
// The default watchdog limit only matters when SOBEL_LOADER_TMO_EN is defined.
package sobel_pkg;

    localparam int unsigned SOBEL_IMG_W   = 512;
    localparam int unsigned SOBEL_IMG_H   = 512;
    localparam int unsigned SOBEL_ADDR_W  = $clog2(SOBEL_IMG_W) + $clog2(SOBEL_IMG_H);
    localparam int unsigned SOBEL_PIX_W   = 8;
    localparam int unsigned SOBEL_TMO_CYC = 2 ** 24;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_KICK = 2'd2,
        LD_RUN  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/sobel_frame_loader_if.sv
// Raster pixel stream bundle feeding the Sobel frame loader.
// Signals:
//   s_pix_tdata   pixel
//   s_pix_tvalid  pixel valid
//   s_pix_tready  sink can accept
//   s_pix_tuser   start of frame (first pixel)
//   s_pix_tlast   end of line (last pixel of a row)
// Modports: master = stream source, slave = loader.
interface sobel_frame_loader_if
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = SOBEL_PIX_W
) ();

    logic [PIX_W-1:0] s_pix_tdata;
    logic             s_pix_tvalid;
    logic             s_pix_tready;
    logic             s_pix_tuser;
    logic             s_pix_tlast;

    modport master (
        output s_pix_tdata,
        output s_pix_tvalid,
        output s_pix_tuser,
        output s_pix_tlast,
        input  s_pix_tready
    );

    modport slave (
        input  s_pix_tdata,
        input  s_pix_tvalid,
        input  s_pix_tuser,
        input  s_pix_tlast,
        output s_pix_tready
    );

endinterface

// File: rtl/sobel_pix_counter.sv
// Raster position counter for the frame loader.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   inc           advance one pixel (x wraps at IMG_W-1 and y increments)
//   restart       the current beat is pixel (0,0): jump to the position after it
//   x, y          current raster position (registered)
//   last_col_c    x == IMG_W-1 (combinational)
//   last_pix_c    position is (IMG_H-1, IMG_W-1) (combinational)
// IMG_W and IMG_H must be powers of two, at least 2.
module sobel_pix_counter #(
    parameter  int unsigned IMG_W = 512,
    parameter  int unsigned IMG_H = 512,
    localparam int unsigned XW    = $clog2(IMG_W),
    localparam int unsigned YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          restart,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last_col_c,
    output logic          last_pix_c
);

    assign last_col_c = (x == XW'(IMG_W - 1));
    assign last_pix_c = last_col_c && (y == YW'(IMG_H - 1));

    // Position register; y wraps naturally after the final line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (restart) begin
            x <= XW'(1);
            y <= '0;
        end else if (inc) begin
            if (last_col_c) begin
                x <= '0;
                y <= y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_frame_loader.sv
// Sobel frame loader: captures one IMG_W x IMG_H raster frame from a pixel stream into the
// engine's frame memory at address {y,x}, then starts the engine and holds the stream off
// until the engine reports done.
// Ports:
//   ap_clk, ap_rst_n         clock, asynchronous active-low reset
//   pix                      pixel stream (slave side)
//   mem_address0/ce0/we0/d0  registered frame memory write port
//   sobel_start, sobel_done  engine ap_start / ap_done handshake
//   err_clr                  clears the sticky error flags
//   err_sof                  sticky: start of frame seen mid-frame
//   err_eol                  sticky: tlast disagreed with the column position
//   err_tmo                  sticky: engine watchdog expired
//   frame_cnt                completed frames (wraps)
// Build option: SOBEL_LOADER_TMO_EN adds the engine watchdog (TMO_CYC cycles); without it
// the loader waits for sobel_done indefinitely and err_tmo is tied low.
module sobel_frame_loader
    import sobel_pkg::*;
#(
    parameter  int unsigned IMG_W   = SOBEL_IMG_W,
    parameter  int unsigned IMG_H   = SOBEL_IMG_H,
    parameter  int unsigned PIX_W   = SOBEL_PIX_W,
`ifdef SOBEL_LOADER_TMO_EN
    parameter  int unsigned TMO_CYC = SOBEL_TMO_CYC,
`endif
    localparam int unsigned XW      = $clog2(IMG_W),
    localparam int unsigned YW      = $clog2(IMG_H),
    localparam int unsigned ADDR_W  = XW + YW
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    sobel_frame_loader_if.slave  pix,
    output logic [ADDR_W-1:0]    mem_address0,
    output logic                 mem_ce0,
    output logic                 mem_we0,
    output logic [PIX_W-1:0]     mem_d0,
    output logic                 sobel_start,
    input  logic                 sobel_done,
    input  logic                 err_clr,
    output logic                 err_sof,
    output logic                 err_eol,
    output logic                 err_tmo,
    output logic [15:0]          frame_cnt
);

    // A start-of-frame beat sits in column 0; it ends a line only for single-column frames.
    localparam bit FIRST_IS_LAST = (IMG_W == 1);

    loader_state_e       state_q;
    loader_state_e       state_d;
    logic                accept_c;
    logic                cnt_inc;
    logic                cnt_restart;
    logic [XW-1:0]       pos_x;
    logic [YW-1:0]       pos_y;
    logic                last_col_c;
    logic                last_pix_c;
    logic                wr_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [PIX_W-1:0]    data_d;
    logic                tready_d;
    logic                start_d;
    logic                sof_set;
    logic                eol_set;
    logic [15:0]         frame_cnt_d;

    assign accept_c = pix.s_pix_tvalid & pix.s_pix_tready;

    sobel_pix_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pix_counter (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .inc        (cnt_inc),
        .restart    (cnt_restart),
        .x          (pos_x),
        .y          (pos_y),
        .last_col_c (last_col_c),
        .last_pix_c (last_pix_c)
    );

`ifdef SOBEL_LOADER_TMO_EN
    localparam int unsigned TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic             tmo_set;
`endif

    // Next-state, memory write and flag-set decode.
    always_comb begin
        state_d     = state_q;
        cnt_inc     = 1'b0;
        cnt_restart = 1'b0;
        wr_d        = 1'b0;
        addr_d      = mem_address0;
        data_d      = mem_d0;
        sof_set     = 1'b0;
        eol_set     = 1'b0;
        frame_cnt_d = frame_cnt;
`ifdef SOBEL_LOADER_TMO_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_set     = 1'b0;
`endif
        case (state_q)
            // Beats before a start of frame are consumed and discarded.
            LD_IDLE: begin
                if (accept_c && pix.s_pix_tuser) begin
                    wr_d        = 1'b1;
                    addr_d      = '0;
                    data_d      = pix.s_pix_tdata;
                    cnt_restart = 1'b1;
                    state_d     = LD_LOAD;
                end
            end
            // Position count is authoritative; a bad tlast is flagged but never realigns it.
            LD_LOAD: begin
                if (accept_c) begin
                    wr_d   = 1'b1;
                    data_d = pix.s_pix_tdata;
                    if (pix.s_pix_tuser) begin
                        sof_set     = 1'b1;
                        addr_d      = '0;
                        cnt_restart = 1'b1;
                        eol_set     = (pix.s_pix_tlast != FIRST_IS_LAST);
                    end else begin
                        addr_d  = {pos_y, pos_x};
                        cnt_inc = 1'b1;
                        eol_set = (pix.s_pix_tlast != last_col_c);
                        if (last_pix_c) begin
                            state_d = LD_KICK;
                        end
                    end
                end
            end
            // Lets the final registered write land before the engine starts.
            LD_KICK: begin
                state_d = LD_RUN;
`ifdef SOBEL_LOADER_TMO_EN
                tmo_cnt_d = '0;
`endif
            end
            LD_RUN: begin
                if (sobel_done) begin
                    state_d     = LD_IDLE;
                    frame_cnt_d = frame_cnt + 16'(1);
                end
`ifdef SOBEL_LOADER_TMO_EN
                else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                    tmo_set = 1'b1;
                    state_d = LD_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            default: state_d = LD_IDLE;
        endcase
        tready_d = (state_d == LD_IDLE) || (state_d == LD_LOAD);
        start_d  = (state_d == LD_RUN);
    end

    // State and registered outputs; a flag being set wins over err_clr in the same cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q          <= LD_IDLE;
            pix.s_pix_tready <= 1'b0;
            mem_address0     <= '0;
            mem_ce0          <= 1'b0;
            mem_we0          <= 1'b0;
            mem_d0           <= '0;
            sobel_start      <= 1'b0;
            err_sof          <= 1'b0;
            err_eol          <= 1'b0;
            frame_cnt        <= '0;
        end else begin
            state_q          <= state_d;
            pix.s_pix_tready <= tready_d;
            mem_address0     <= addr_d;
            mem_ce0          <= wr_d;
            mem_we0          <= wr_d;
            mem_d0           <= data_d;
            sobel_start      <= start_d;
            err_sof          <= sof_set | (err_sof & ~err_clr);
            err_eol          <= eol_set | (err_eol & ~err_clr);
            frame_cnt        <= frame_cnt_d;
        end
    end

`ifdef SOBEL_LOADER_TMO_EN
    // Engine watchdog counter and its sticky flag.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tmo_cnt_q <= '0;
            err_tmo   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo   <= tmo_set | (err_tmo & ~err_clr);
        end
    end
`else
    assign err_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_loader.sv
// Directed bench for sobel_frame_loader on a 4x4 frame.
// Define SOBEL_LOADER_TMO_EN to also exercise the engine watchdog with TMO_CYC=100.
module tb_sobel_frame_loader;

    localparam int unsigned W = 4;
    localparam int unsigned H = 4;
    localparam int unsigned N = W * H;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [3:0]  mem_address0;
    logic        mem_ce0;
    logic        mem_we0;
    logic [7:0]  mem_d0;
    logic        sobel_start;
    logic        sobel_done = 1'b0;
    logic        err_clr = 1'b0;
    logic        err_sof;
    logic        err_eol;
    logic        err_tmo;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    int         wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] mem_m [N];

    sobel_frame_loader_if #(.PIX_W(8)) pix ();

    sobel_frame_loader #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (8)
`ifdef SOBEL_LOADER_TMO_EN
        , .TMO_CYC (100)
`endif
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .pix          (pix),
        .mem_address0 (mem_address0),
        .mem_ce0      (mem_ce0),
        .mem_we0      (mem_we0),
        .mem_d0       (mem_d0),
        .sobel_start  (sobel_start),
        .sobel_done   (sobel_done),
        .err_clr      (err_clr),
        .err_sof      (err_sof),
        .err_eol      (err_eol),
        .err_tmo      (err_tmo),
        .frame_cnt    (frame_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    // Write log, sampled mid-cycle.
    always @(negedge ap_clk) begin
        if (mem_ce0 === 1'b1 && mem_we0 === 1'b1) begin
            wr_addr_q.push_back(int'(mem_address0));
            wr_data_q.push_back(mem_d0);
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic rebuild_mem();
        for (int i = 0; i < int'(N); i++) mem_m[i] = 8'h00;
        for (int i = 0; i < wr_addr_q.size(); i++) mem_m[wr_addr_q[i]] = wr_data_q[i];
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
        int n = 0;
        @(negedge ap_clk);
        pix.s_pix_tdata  = d;
        pix.s_pix_tuser  = u;
        pix.s_pix_tlast  = l;
        pix.s_pix_tvalid = 1'b1;
        while (pix.s_pix_tready !== 1'b1 && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        checks++;
        if (pix.s_pix_tready !== 1'b1) begin
            errors++;
            $display("FAIL send_beat: tready=%b after %0d cycles, required 1", pix.s_pix_tready, n);
        end else begin
            @(posedge ap_clk);
        end
        #1;
        pix.s_pix_tvalid = 1'b0;
        pix.s_pix_tuser  = 1'b0;
        pix.s_pix_tlast  = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (sobel_start !== 1'b1 && n < 20) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        checks++;
        if (sobel_start !== 1'b1) begin
            errors++;
            $display("FAIL wait_start: sobel_start=%b, required 1 within 20 cycles", sobel_start);
        end
    endtask

    task automatic pulse_done();
        @(negedge ap_clk);
        sobel_done = 1'b1;
        @(posedge ap_clk);
        #1;
        sobel_done = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        checks++;
        if ({pix.s_pix_tready, sobel_start, mem_ce0, mem_we0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: tready/start/ce/we=%b, required 0000",
                     {pix.s_pix_tready, sobel_start, mem_ce0, mem_we0});
        end
        checks++;
        if ({mem_address0, mem_d0, frame_cnt} !== 28'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%0d data=%h frame_cnt=%0d, required 0 0 0",
                     mem_address0, mem_d0, frame_cnt);
        end
        checks++;
        if ({err_sof, err_eol, err_tmo} !== 3'b000) begin
            errors++;
            $display("FAIL reset_err: err=%b, required 000", {err_sof, err_eol, err_tmo});
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        checks++;
        if (pix.s_pix_tready !== 1'b1 || sobel_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: tready=%b start=%b, required 1 0", pix.s_pix_tready, sobel_start);
        end
    endtask

    task automatic test_frame();
        clear_log();
        for (int i = 0; i < int'(N); i++) send_beat(8'(8'h10 + i), i == 0, (i % 4) == 3);
        checks++;
        if (pix.s_pix_tready !== 1'b0) begin
            errors++;
            $display("FAIL frame_tready_drop: tready=%b, required 0", pix.s_pix_tready);
        end
        checks++;
        if (mem_ce0 !== 1'b1 || mem_we0 !== 1'b1 || mem_address0 !== 4'd15 || mem_d0 !== 8'h1F) begin
            errors++;
            $display("FAIL frame_last_write: ce=%b we=%b addr=%0d data=%h, required 1 1 15 1f",
                     mem_ce0, mem_we0, mem_address0, mem_d0);
        end
        checks++;
        if (sobel_start !== 1'b0) begin
            errors++;
            $display("FAIL frame_kick: sobel_start=%b, required 0", sobel_start);
        end
        @(posedge ap_clk);
        #1;
        checks++;
        if (sobel_start !== 1'b1 || mem_ce0 !== 1'b0) begin
            errors++;
            $display("FAIL frame_start: start=%b ce=%b, required 1 0", sobel_start, mem_ce0);
        end
        repeat (3) @(posedge ap_clk);
        #1;
        checks++;
        if (sobel_start !== 1'b1 || pix.s_pix_tready !== 1'b0) begin
            errors++;
            $display("FAIL frame_run_hold: start=%b tready=%b, required 1 0", sobel_start, pix.s_pix_tready);
        end
        checks++;
        if (wr_addr_q.size() != 16) begin
            errors++;
            $display("FAIL frame_write_count: %0d writes, required 16", wr_addr_q.size());
        end
        for (int i = 0; i < wr_addr_q.size() && i < 16; i++) begin
            checks++;
            if (wr_addr_q[i] != i || wr_data_q[i] !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL frame_write[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i, 8'(8'h10 + i));
            end
        end
        pulse_done();
        checks++;
        if (sobel_start !== 1'b0 || frame_cnt !== 16'd1 || pix.s_pix_tready !== 1'b1) begin
            errors++;
            $display("FAIL frame_done: start=%b frame_cnt=%0d tready=%b, required 0 1 1",
                     sobel_start, frame_cnt, pix.s_pix_tready);
        end
    endtask

    task automatic test_idle_drop();
        clear_log();
        pulse_done();
        checks++;
        if (frame_cnt !== 16'd1 || sobel_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_done_ignored: frame_cnt=%0d start=%b, required 1 0", frame_cnt, sobel_start);
        end
        for (int i = 0; i < 3; i++) send_beat(8'(8'hE0 + i), 1'b0, 1'b0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if (wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL idle_drop: %0d writes, required 0", wr_addr_q.size());
        end
        for (int i = 0; i < int'(N); i++) send_beat(8'(8'h80 + i), i == 0, (i % 4) == 3);
        wait_start();
        checks++;
        if (wr_addr_q.size() != 16 || wr_addr_q[0] != 0 || wr_data_q[0] !== 8'h80) begin
            errors++;
            $display("FAIL idle_first_write: count=%0d addr=%0d data=%h, required 16 0 80",
                     wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]);
        end
        pulse_done();
        checks++;
        if (frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL idle_frame_cnt: %0d, required 2", frame_cnt);
        end
    endtask

    task automatic test_sof_mid();
        clear_log();
        for (int i = 0; i < 6; i++) send_beat(8'(8'h20 + i), i == 0, i == 3);
        checks++;
        if (err_sof !== 1'b0) begin
            errors++;
            $display("FAIL sof_pre: err_sof=%b, required 0", err_sof);
        end
        send_beat(8'h66, 1'b1, 1'b0);
        checks++;
        if (err_sof !== 1'b1 || mem_ce0 !== 1'b1 || mem_address0 !== 4'd0 || mem_d0 !== 8'h66) begin
            errors++;
            $display("FAIL sof_restart: err_sof=%b ce=%b addr=%0d data=%h, required 1 1 0 66",
                     err_sof, mem_ce0, mem_address0, mem_d0);
        end
        for (int k = 1; k < 15; k++) send_beat(8'(8'h70 + k), 1'b0, (k % 4) == 3);
        checks++;
        if (pix.s_pix_tready !== 1'b1 || sobel_start !== 1'b0) begin
            errors++;
            $display("FAIL sof_not_early: tready=%b start=%b, required 1 0", pix.s_pix_tready, sobel_start);
        end
        send_beat(8'h7F, 1'b0, 1'b1);
        checks++;
        if (pix.s_pix_tready !== 1'b0) begin
            errors++;
            $display("FAIL sof_complete: tready=%b, required 0", pix.s_pix_tready);
        end
        wait_start();
        rebuild_mem();
        checks++;
        if (mem_m[0] !== 8'h66) begin
            errors++;
            $display("FAIL sof_mem[0]: %h, required 66", mem_m[0]);
        end
        for (int k = 1; k < 16; k++) begin
            checks++;
            if (mem_m[k] !== 8'(8'h70 + k)) begin
                errors++;
                $display("FAIL sof_mem[%0d]: %h, required %h", k, mem_m[k], 8'(8'h70 + k));
            end
        end
        checks++;
        if (err_eol !== 1'b0) begin
            errors++;
            $display("FAIL sof_no_eol: err_eol=%b, required 0", err_eol);
        end
        pulse_done();
        @(negedge ap_clk);
        err_clr = 1'b1;
        @(posedge ap_clk);
        #1;
        err_clr = 1'b0;
        checks++;
        if (err_sof !== 1'b0 || frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL sof_clear: err_sof=%b frame_cnt=%0d, required 0 3", err_sof, frame_cnt);
        end
    endtask

    task automatic test_eol();
        clear_log();
        for (int i = 0; i < 3; i++) send_beat(8'(8'h50 + i), i == 0, i == 2);
        checks++;
        if (err_eol !== 1'b1) begin
            errors++;
            $display("FAIL eol_set: err_eol=%b, required 1", err_eol);
        end
        // Beat 3 lacks tlast at x=3: a new error in the same cycle as err_clr must stick.
        err_clr = 1'b1;
        send_beat(8'h53, 1'b0, 1'b0);
        err_clr = 1'b0;
        checks++;
        if (err_eol !== 1'b1 || mem_address0 !== 4'd3 || mem_d0 !== 8'h53) begin
            errors++;
            $display("FAIL eol_set_wins: err_eol=%b addr=%0d data=%h, required 1 3 53",
                     err_eol, mem_address0, mem_d0);
        end
        for (int i = 4; i < int'(N); i++) send_beat(8'(8'h50 + i), 1'b0, (i % 4) == 3);
        wait_start();
        checks++;
        if (wr_addr_q.size() != 16 || wr_addr_q[15] != 15) begin
            errors++;
            $display("FAIL eol_no_realign: count=%0d last_addr=%0d, required 16 15",
                     wr_addr_q.size(), wr_addr_q[15]);
        end
        pulse_done();
        @(negedge ap_clk);
        err_clr = 1'b1;
        @(posedge ap_clk);
        #1;
        err_clr = 1'b0;
        checks++;
        if (err_eol !== 1'b0 || frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL eol_clear: err_eol=%b frame_cnt=%0d, required 0 4", err_eol, frame_cnt);
        end
    endtask

    task automatic test_gaps();
        clear_log();
        for (int i = 0; i < int'(N); i++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge ap_clk);
            send_beat(8'(8'h30 + i), i == 0, (i % 4) == 3);
        end
        wait_start();
        rebuild_mem();
        checks++;
        if (wr_addr_q.size() != 16) begin
            errors++;
            $display("FAIL gaps_count: %0d writes, required 16", wr_addr_q.size());
        end
        for (int i = 0; i < int'(N); i++) begin
            checks++;
            if (mem_m[i] !== 8'(8'h30 + i)) begin
                errors++;
                $display("FAIL gaps_mem[%0d]: %h, required %h", i, mem_m[i], 8'(8'h30 + i));
            end
        end
        pulse_done();
        checks++;
        if (frame_cnt !== 16'd5) begin
            errors++;
            $display("FAIL gaps_frame_cnt: %0d, required 5", frame_cnt);
        end
    endtask

    task automatic test_reset_in_run();
        for (int i = 0; i < int'(N); i++) send_beat(8'(8'h40 + i), i == 0, (i % 4) == 3);
        wait_start();
        @(negedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (sobel_start !== 1'b0 || pix.s_pix_tready !== 1'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_run_async: start=%b tready=%b frame_cnt=%0d, required 0 0 0",
                     sobel_start, pix.s_pix_tready, frame_cnt);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        checks++;
        if (pix.s_pix_tready !== 1'b1 || sobel_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_run_idle: tready=%b start=%b, required 1 0", pix.s_pix_tready, sobel_start);
        end
        clear_log();
        send_beat(8'h99, 1'b0, 1'b0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if (wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL rst_run_drop: %0d writes, required 0", wr_addr_q.size());
        end
    endtask

`ifdef SOBEL_LOADER_TMO_EN
    task automatic test_tmo();
        int n = 0;
        for (int i = 0; i < int'(N); i++) send_beat(8'(8'h60 + i), i == 0, (i % 4) == 3);
        wait_start();
        while (sobel_start === 1'b1 && n < 300) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        checks++;
        if (n != 100) begin
            errors++;
            $display("FAIL tmo_cycles: start held %0d cycles, required 100", n);
        end
        checks++;
        if (err_tmo !== 1'b1 || frame_cnt !== 16'd0 || pix.s_pix_tready !== 1'b1) begin
            errors++;
            $display("FAIL tmo_flags: err_tmo=%b frame_cnt=%0d tready=%b, required 1 0 1",
                     err_tmo, frame_cnt, pix.s_pix_tready);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pix.s_pix_tdata  = 8'h00;
        pix.s_pix_tvalid = 1'b0;
        pix.s_pix_tuser  = 1'b0;
        pix.s_pix_tlast  = 1'b0;
        test_reset();
        test_frame();
        test_idle_drop();
        test_sof_mid();
        test_eol();
        test_gaps();
        test_reset_in_run();
`ifdef SOBEL_LOADER_TMO_EN
        test_tmo();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
